double2int_pe: RTL and testbench

DOUBLE2INT_PE -- requirements
Module: double2int_pe

---
 rtl/double2int_pe_pkg.sv | 15 +
 rtl/double2int_pe_register_pipe.sv | 26 ++
 rtl/double2int_pe.sv | 130 +++++++++++++
 tb/tb_double2int_pe.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/double2int_pe_pkg.sv
// double2int_pe_pkg: shared widths, constants and types for the double-to-int64 converter
package double2int_pe_pkg;
  localparam int dwidth_double = 64;
  localparam int exp_bias = 1023;
  localparam int exp_width = 11;
  localparam int man_width = 52;
  localparam logic [63:0] int_max = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] int_min = 64'h8000_0000_0000_0000;
  typedef struct packed {
    logic invalid;
    logic overflow;
    logic inexact;
  } flags_t;
  typedef enum logic [1:0] {C_NORM, C_SMALL, C_OVF, C_NAN} cls_t;
endpackage

// File: rtl/double2int_pe_register_pipe.sv
// register_pipe: valid-gated delay line; each stage holds its data until a new valid word arrives
module register_pipe #(
  parameter int width = 64,
  parameter int numPipeStage = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [width-1:0] d,
  output logic [width-1:0] q
);
  logic [numPipeStage-2:0] v;
  logic [width-1:0] r [numPipeStage];
  always_ff @(posedge clk) begin
    if (rst) begin
      v <= '0;
      for (int i = 0; i < numPipeStage; i++) r[i] <= '0;
    end else begin
      v[0] <= en;
      for (int i = 1; i < numPipeStage - 1; i++) v[i] <= v[i-1];
      if (en) r[0] <= d;
      for (int i = 1; i < numPipeStage; i++) if (v[i-1]) r[i] <= r[i-1];
    end
  end
  assign q = r[numPipeStage-1];
endmodule

// File: rtl/double2int_pe.sv
// double2int_pe: 4-stage binary64 to signed int64 converter (truncate / RNE) with bypass
module double2int_pe
  import double2int_pe_pkg::*;
#(
  parameter int latency = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [dwidth_double-1:0] inp1,
  input  logic [1:0]               op,
  output logic [63:0]              out1,
  output logic                     out_valid,
  output logic [2:0]               flags
);
  logic s1_v, s1_sign, s1_nan, s1_inf, s1_zero, s1_sub;
  logic [1:0] s1_op;
  logic [exp_width-1:0] s1_exp;
  logic [man_width-1:0] s1_man;
  logic s2_v, s2_sign, s2_left, s2_one, s2_nz;
  logic [1:0] s2_op;
  logic [man_width-1:0] s2_man;
  logic [3:0] s2_lsh;
  logic [5:0] s2_rsh;
  cls_t s2_cls;
  logic s3_v, s3_op0, s3_sign, s3_inx;
  logic [63:0] s3_mag;
  cls_t s3_cls;
  logic ov_q, sel_q;
  logic [63:0] conv_q, bp_q;
  flags_t flags_q;
  logic signed [12:0] e;
  cls_t cls2;
  logic [3:0] lsh2;
  logic [5:0] rsh2;
  logic left2, one2;
  logic [man_width:0] sig;
  logic [116:0] ext;
  logic [man_width:0] ip;
  logic g, st, inc, inx3;
  logic [63:0] mag3, res4;
  logic ovf4;
  flags_t f4;
  always_comb begin
    e = $signed({2'b00, s1_exp}) - $signed(13'(exp_bias));
    left2 = e >= 13'sd52;
    lsh2 = left2 ? 4'(e - 13'sd52) : 4'd0;
    rsh2 = left2 ? 6'd0 : 6'(13'sd52 - e);
    one2 = (e == -13'sd1) & |s1_man;
    cls2 = s1_nan ? C_NAN
         : s1_inf ? C_OVF
         : (s1_zero | s1_sub | e[12]) ? C_SMALL
         : (e > 13'sd63) ? C_OVF
         : (e == 13'sd63) ? ((s1_sign & ~|s1_man) ? C_NORM : C_OVF)
         : C_NORM;
  end
  // Right shifts keep the discarded bits below the binary point for guard/sticky.
  always_comb begin
    sig = {1'b1, s2_man};
    ext = {sig, 64'b0} >> s2_rsh;
    ip = ext[116:64];
    g = ext[63];
    st = |ext[62:0];
    inc = s2_op[1] & g & (st | ip[0]);
    mag3 = (s2_cls == C_SMALL) ? {63'b0, s2_op[1] & s2_one}
         : s2_left ? ({11'b0, sig} << s2_lsh)
         : ({11'b0, ip} + {63'b0, inc});
    inx3 = (s2_cls == C_SMALL) ? s2_nz : (s2_cls == C_NORM) & ~s2_left & (g | st);
  end
  always_comb begin
    ovf4 = (s3_cls == C_OVF) | (s3_sign ? s3_mag[63] & |s3_mag[62:0] : s3_mag[63]);
    res4 = (s3_cls == C_NAN) ? int_min
         : ovf4 ? (s3_sign ? int_min : int_max)
         : (s3_sign ? -s3_mag : s3_mag);
    f4.invalid = s3_cls == C_NAN;
    f4.overflow = (s3_cls != C_NAN) & ovf4;
    f4.inexact = (s3_cls != C_NAN) & ~ovf4 & s3_inx;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      s3_v <= 1'b0;
      ov_q <= 1'b0;
      sel_q <= 1'b0;
      conv_q <= '0;
      flags_q <= '0;
    end else begin
      s1_v <= in_valid;
      s2_v <= s1_v;
      s3_v <= s2_v;
      ov_q <= s3_v;
      if (s3_v) sel_q <= ~s3_op0;
      if (s3_v & s3_op0) conv_q <= res4;
      flags_q <= (s3_v & s3_op0) ? f4 : '0;
    end
    s1_op <= op;
    s1_sign <= inp1[63];
    s1_exp <= inp1[62:52];
    s1_man <= inp1[51:0];
    s1_nan <= &inp1[62:52] & |inp1[51:0];
    s1_inf <= &inp1[62:52] & ~|inp1[51:0];
    s1_zero <= ~|inp1[62:0];
    s1_sub <= ~|inp1[62:52] & |inp1[51:0];
    s2_op <= s1_op;
    s2_sign <= s1_sign;
    s2_man <= s1_man;
    s2_cls <= cls2;
    s2_left <= left2;
    s2_lsh <= lsh2;
    s2_rsh <= rsh2;
    s2_one <= one2;
    s2_nz <= ~s1_zero;
    s3_op0 <= s2_op[0];
    s3_sign <= s2_sign;
    s3_cls <= s2_cls;
    s3_mag <= mag3;
    s3_inx <= inx3;
  end
  register_pipe #(.width(dwidth_double), .numPipeStage(latency)) u_bypass (
    .clk(clk),
    .rst(rst),
    .en(in_valid & ~op[0]),
    .d(inp1),
    .q(bp_q)
  );
  assign out1 = sel_q ? bp_q : conv_q;
  assign out_valid = ov_q;
  assign flags = flags_q;
endmodule

// File: tb/tb_double2int_pe.sv
// tb_double2int_pe: table vectors, directed sequences and random stimulus against a real-arithmetic model
module tb_double2int_pe;
  localparam real p63 = 9223372036854775808.0;
  logic clk = 1'b0;
  logic rst, in_valid;
  logic [63:0] inp1, out1;
  logic [1:0] op;
  logic out_valid;
  logic [2:0] flags;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  typedef struct {
    logic [63:0] out;
    logic [2:0] fl;
    int due;
  } exp_t;
  exp_t sb[$];
  typedef struct {
    logic [63:0] x;
    logic [1:0] op;
    logic [63:0] r;
    logic [2:0] f;
  } vec_t;
  vec_t tv[$];

  double2int_pe #(.latency(4)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .inp1(inp1),
    .op(op),
    .out1(out1),
    .out_valid(out_valid),
    .flags(flags)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic void model(input logic [63:0] b, input logic [1:0] o,
                                output logic [63:0] r, output logic [2:0] f);
    real x, a, fl, fr;
    longint li;
    if (!o[0]) begin
      r = b;
      f = 3'b000;
      return;
    end
    if (&b[62:52] && |b[51:0]) begin
      r = 64'h8000_0000_0000_0000;
      f = 3'b100;
      return;
    end
    x = $bitstoreal(b);
    if (x >= p63) begin
      r = 64'h7FFF_FFFF_FFFF_FFFF;
      f = 3'b010;
    end else if (x < -p63) begin
      r = 64'h8000_0000_0000_0000;
      f = 3'b010;
    end else if (x == -p63) begin
      r = 64'h8000_0000_0000_0000;
      f = 3'b000;
    end else begin
      a = b[63] ? -x : x;
      fl = $floor(a);
      fr = a - fl;
      li = longint'(fl);
      if (o[1] && (fr > 0.5 || (fr == 0.5 && li[0]))) li++;
      r = b[63] ? -li : li;
      f = {2'b00, fr != 0.0};
    end
  endfunction

  function automatic logic [63:0] rnd_double();
    logic [63:0] rr;
    logic [10:0] ex;
    logic [51:0] mn;
    rr = {$urandom, $urandom};
    mn = rr[51:0];
    case ($urandom_range(0, 9))
      0: begin ex = 11'd0; if ($urandom_range(0, 1) == 0) mn = '0; end
      1: begin ex = 11'h7FF; if ($urandom_range(0, 1) == 0) mn = '0; end
      default: ex = 11'($urandom_range(1016, 1090));
    endcase
    if ($urandom_range(0, 2) == 0) mn[39:0] = '0;
    return {1'($urandom_range(0, 1)), ex, mn};
  endfunction

  task automatic drive(input logic [63:0] x, input logic [1:0] o, input logic [63:0] eo, input logic [2:0] ef);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    inp1 = x;
    op = o;
    sb.push_back('{eo, ef, cyc + 4});
  endtask

  task automatic drive_m(input logic [63:0] x, input logic [1:0] o);
    logic [63:0] r;
    logic [2:0] f;
    model(x, o, r, f);
    drive(x, o, r, f);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      inp1 = {$urandom, $urandom};
      op = 2'($urandom_range(0, 3));
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (out_valid) begin
      if (sb.size() == 0) begin
        chk("spurious out_valid", 64'(out_valid), 64'd0);
      end else begin
        e = sb.pop_front();
        chk("out1", out1, e.out);
        chk("flags", 64'(flags), 64'(e.fl));
        chk("latency cycle", 64'(cyc), 64'(e.due));
      end
    end else begin
      chk("idle flags", 64'(flags), 64'd0);
      if (sb.size() > 0 && sb[0].due <= cyc) begin
        n_chk++;
        n_fail++;
        $display("FAIL missing result: out_valid=0 at cycle %0d, expected %h due at %0d", cyc, sb[0].out, sb[0].due);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    tv.push_back('{64'h3FF0000000000000, 2'b01, 64'h0000000000000001, 3'b000});
    tv.push_back('{64'h400C000000000000, 2'b01, 64'h0000000000000003, 3'b001});
    tv.push_back('{64'h400C000000000000, 2'b11, 64'h0000000000000004, 3'b001});
    tv.push_back('{64'h4004000000000000, 2'b11, 64'h0000000000000002, 3'b001});
    tv.push_back('{64'hBFF8000000000000, 2'b01, 64'hFFFFFFFFFFFFFFFF, 3'b001});
    tv.push_back('{64'hBFF8000000000000, 2'b11, 64'hFFFFFFFFFFFFFFFE, 3'b001});
    tv.push_back('{64'h43F0000000000000, 2'b01, 64'h7FFFFFFFFFFFFFFF, 3'b010});
    tv.push_back('{64'hC3E0000000000000, 2'b01, 64'h8000000000000000, 3'b000});
    tv.push_back('{64'h7FF8000000000000, 2'b01, 64'h8000000000000000, 3'b100});
    tv.push_back('{64'h3FE0000000000000, 2'b11, 64'h0000000000000000, 3'b001});
    tv.push_back('{64'h3FE8000000000000, 2'b11, 64'h0000000000000001, 3'b001});
    tv.push_back('{64'hBFE0000000000000, 2'b11, 64'h0000000000000000, 3'b001});
    tv.push_back('{64'h8000000000000000, 2'b11, 64'h0000000000000000, 3'b000});
    tv.push_back('{64'h0000000000000001, 2'b11, 64'h0000000000000000, 3'b001});
    tv.push_back('{64'h7FF0000000000000, 2'b01, 64'h7FFFFFFFFFFFFFFF, 3'b010});
    tv.push_back('{64'hFFF0000000000000, 2'b11, 64'h8000000000000000, 3'b010});
    tv.push_back('{64'h43E0000000000000, 2'b01, 64'h7FFFFFFFFFFFFFFF, 3'b010});
    tv.push_back('{64'hC3E0000000000001, 2'b01, 64'h8000000000000000, 3'b010});
    tv.push_back('{64'h43DFFFFFFFFFFFFF, 2'b11, 64'h7FFFFFFFFFFFFC00, 3'b000});
    tv.push_back('{64'h123456789ABCDEF0, 2'b00, 64'h123456789ABCDEF0, 3'b000});
    tv.push_back('{64'h7FF8000000000000, 2'b10, 64'h7FF8000000000000, 3'b000});
    rst = 1'b1;
    in_valid = 1'b0;
    inp1 = '0;
    op = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset out1", out1, 64'd0);
    chk("reset flags", 64'(flags), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    foreach (tv[i]) drive(tv[i].x, tv[i].op, tv[i].r, tv[i].f);
    idle(6);
    for (int i = 0; i < 8; i++) drive_m(64'h123456789ABCDEF0, 2'(i));
    idle(6);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      drive_m(rnd_double(), 2'($urandom_range(0, 3)));
    end
    idle(6);
    for (int i = 0; i < 3; i++) drive_m(64'h4024000000000000, 2'b01);
    @(posedge clk);
    #1;
    rst = 1'b1;
    in_valid = 1'b1;
    inp1 = 64'h3FF0000000000000;
    op = 2'b01;
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post-reset out_valid", 64'(out_valid), 64'd0);
      chk("post-reset out1", out1, 64'd0);
    end
    drive_m(64'h3FF0000000000000, 2'b01);
    drive_m(64'hDEADBEEFCAFEF00D, 2'b00);
    idle(1);
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    chk("scoreboard drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
